fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the LEGv8 pipeline. Owns the fetch PC, drives the 6-bit word address of
//   the 64-word instruction ROM, and registers the fetched word into the IF/ID stage with a valid bit.
//   Applies stall and branch redirect/flush requests, and detects the end-of-program idiom
//   (CBZ XZR,#0 = 32'hb400001f). Out-of-range fetches raise a sticky fault.
// PARAMETERS
//   N         64           PC / datapath width
//   IMEM_AW   6            instruction ROM word-address width (ROM depth = 2**IMEM_AW words)
//   RESET_PC  0            PC loaded on reset (byte address, word aligned)
//   HALT_WORD 32'hb400001f encoding that ends fetch
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   reset        in   1        synchronous, active-high
//   imem_addr    out  IMEM_AW  ROM word address = pc_F[IMEM_AW+1:2] (combinational)
//   imem_q       in   32       ROM read data, combinational from imem_addr
//   stall_F      in   1        hazard unit: hold PC and IF/ID
//   redirect     in   1        taken branch: load redirect_pc, flush IF/ID
//   redirect_pc  in   N        branch target (byte address)
//   pc_F         out  N        current fetch PC
//   instr_D      out  32       IF/ID instruction
//   pc_D         out  N        IF/ID PC of instr_D
//   valid_D      out  1        instr_D holds a real instruction
//   halted       out  1        HALT_WORD issued, fetch stopped
//   fault        out  1        sticky: misaligned or out-of-range PC
//   fetch_count  out  32       instructions issued (valid_D rising loads) since reset
// BEHAVIOUR
//   Reset (sync): pc_F=RESET_PC, instr_D=0, pc_D=0, valid_D=0, halted=0, fault=0, fetch_count=0, state=BOOT.
//   Reset mid-operation overrides everything in the same edge; no other input acts that cycle.
//   FSM states: BOOT, RUN, HALT, FAULT.
//   BOOT: one bubble cycle; valid_D=0, PC held, inputs ignored; -> RUN.
//   RUN, priority redirect > stall > issue:
//     redirect=1: if redirect_pc[1:0]!=0 or redirect_pc >= 4*2**IMEM_AW -> FAULT (pc_F unchanged);
//       else pc_F<=redirect_pc. Either way instr_D<=0, valid_D<=0 (flush). Overrides stall_F.
//     stall_F=1 (no redirect): pc_F, instr_D, pc_D, valid_D, fetch_count all hold.
//     issue: instr_D<=imem_q, pc_D<=pc_F, valid_D<=1, fetch_count+=1 (wraps mod 2**32).
//       If imem_q==HALT_WORD -> HALT, pc_F held.
//       Else if pc_F+4 == 4*2**IMEM_AW -> FAULT after issuing (no wrap to 0).
//       Else pc_F<=pc_F+4 (N-bit add).
//   HALT: halted=1; valid_D<=0 next cycle and stays 0; pc_F held; redirect and stall_F ignored.
//   FAULT: fault=1; valid_D<=0; pc_F held; all inputs ignored until reset.
//   Latency: word at pc_F appears on instr_D/valid_D one cycle later. Issue rate: 1 word/cycle.
//   halted and fault are mutually exclusive; the first state entered wins.
// TESTING
//   1 reset, then 4 free cycles, ROM[0..3]=A,B,C,D -> cycle1 valid_D=0;
//     then instr_D=A,B,C at pc_D=0,4,8; fetch_count=3.
//   2 stall_F=1 for 3 cycles at pc_F=8 -> instr_D, pc_D, pc_F and fetch_count frozen;
//     after release the next issued word is ROM[2].
//   3 redirect=1, redirect_pc=0x40, stall_F=1 in the same cycle -> next: valid_D=0, pc_F=0x40;
//     following: instr_D=ROM[16].
//   4 ROM[5]=32'hb400001f reached sequentially -> instr_D=b400001f, valid_D=1 once, then halted=1,
//     valid_D=0, pc_F=0x14 stays put.
//   5 redirect_pc=0x102 (misaligned), and separately 0x100 (out of range) -> fault=1, valid_D=0;
//     sequential fetch at pc_F=0xFC without halt -> issue ROM[63] then fault=1.
//   6 assert reset while in HALT and while in RUN mid-stall -> all outputs return to reset values,
//     BOOT bubble, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: LEGv8 instruction-fetch sequencer.
// Owns the fetch PC and addresses the instruction ROM. It registers each fetched
// word into IF/ID together with a valid bit. Stall and branch-redirect requests
// are applied here, fetch stops on the end-of-program idiom, and an illegal PC
// raises a sticky fault.
module fetch_ctrl #(
  parameter int unsigned       N         = 64,
  parameter int unsigned       IMEM_AW   = 6,
  parameter logic [N-1:0]      RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'hb400001f
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  input  logic               stall_F,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_pc,
  output logic [N-1:0]       pc_F,
  output logic [31:0]        instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  // First byte address past the end of the ROM.
  localparam int unsigned ROM_BYTES = 4 << IMEM_AW;
  localparam logic [N-1:0] PC_LIMIT = N'(ROM_BYTES);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e       state_q;
  logic [N-1:0] pc_f_q;
  logic [31:0]  instr_d_q;
  logic [N-1:0] pc_d_q;
  logic         valid_d_q;
  logic         halted_q;
  logic         fault_q;
  logic [31:0]  count_q;

  logic [N-1:0] pc_inc;
  logic         redirect_bad;

  // Sequential successor and redirect-target legality.
  always_comb begin
    pc_inc       = pc_f_q + N'(4);
    redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);
  end

  // Fetch FSM: redirect > stall > issue while running; halt/fault states are terminal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_f_q    <= RESET_PC;
      instr_d_q <= '0;
      pc_d_q    <= '0;
      valid_d_q <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          valid_d_q <= 1'b0;
          state_q   <= RUN;
        end
        RUN: begin
          if (redirect) begin
            instr_d_q <= '0;
            valid_d_q <= 1'b0;
            if (redirect_bad) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_f_q <= redirect_pc;
            end
          end else if (!stall_F) begin
            instr_d_q <= imem_q;
            pc_d_q    <= pc_f_q;
            valid_d_q <= 1'b1;
            count_q   <= count_q + 32'd1;
            if (imem_q == HALT_WORD) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else if (pc_inc == PC_LIMIT) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_f_q <= pc_inc;
            end
          end
        end
        HALT: begin
          valid_d_q <= 1'b0;
          halted_q  <= 1'b1;
        end
        FAULT: begin
          valid_d_q <= 1'b0;
          fault_q   <= 1'b1;
        end
        default: begin
          state_q   <= FAULT;
          valid_d_q <= 1'b0;
          fault_q   <= 1'b1;
        end
      endcase
    end
  end

  // ROM word address is a direct slice of the fetch PC.
  assign imem_addr   = pc_f_q[IMEM_AW+1:2];
  assign pc_F        = pc_f_q;
  assign instr_D     = instr_d_q;
  assign pc_D        = pc_d_q;
  assign valid_D     = valid_d_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a cycle-level reference model.
module tb_fetch_ctrl;
  localparam int unsigned N  = 64;
  localparam int unsigned AW = 6;
  localparam logic [31:0] HW = 32'hb400001f;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall_F = 1'b0;
  logic          redirect = 1'b0;
  logic [N-1:0]  redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [N-1:0]  pc_F;
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;
  logic          valid_D;
  logic          halted;
  logic          fault;
  logic [31:0]   fetch_count;

  logic [31:0] rom [64];
  assign imem_q = rom[imem_addr];

  fetch_ctrl #(.N(N), .IMEM_AW(AW), .RESET_PC('0), .HALT_WORD(HW)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .stall_F(stall_F), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what fetch must look like, expressed as flags and arithmetic.
  logic [63:0] m_pc = 0;
  logic [31:0] m_instr = 0;
  logic [63:0] m_pcd = 0;
  logic        m_valid = 0;
  logic        m_started = 0;
  logic        m_halted = 0;
  logic        m_faulted = 0;
  logic [31:0] m_count = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 0; m_instr <= 0; m_pcd <= 0; m_valid <= 0;
      m_started <= 0; m_halted <= 0; m_faulted <= 0; m_count <= 0;
    end else if (!m_started) begin
      m_started <= 1;
      m_valid   <= 0;
    end else if (m_halted || m_faulted) begin
      m_valid <= 0;
    end else if (redirect) begin
      m_instr <= 0;
      m_valid <= 0;
      if ((redirect_pc % 4) != 0 || redirect_pc >= 64'd256) m_faulted <= 1;
      else m_pc <= redirect_pc;
    end else if (!stall_F) begin
      m_instr <= rom[m_pc / 4];
      m_pcd   <= m_pc;
      m_valid <= 1;
      m_count <= m_count + 1;
      if (rom[m_pc / 4] == HW) m_halted <= 1;
      else if (m_pc + 4 == 64'd256) m_faulted <= 1;
      else m_pc <= m_pc + 4;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_F", pc_F, m_pc);
      check("imem_addr", 64'(imem_addr), m_pc / 4);
      check("instr_D", instr_D, m_instr);
      check("pc_D", pc_D, m_pcd);
      check("valid_D", valid_D, m_valid);
      check("halted", halted, m_halted);
      check("fault", fault, m_faulted);
      check("fetch_count", fetch_count, m_count);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for one edge, release, and pass the boot bubble.
  task automatic restart();
    reset = 1'b1; redirect = 1'b0; stall_F = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("boot_valid", valid_D, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
    cyc(1);
    chk_en = 1'b1;

    // Reset values, boot bubble, first issues
    check("rst_pc", pc_F, 0);
    check("rst_valid", valid_D, 0);
    check("rst_cnt", fetch_count, 0);
    check("rst_instr", instr_D, 0);
    reset = 1'b0;
    cyc(1);
    check("boot_valid", valid_D, 0);
    check("boot_pc", pc_F, 0);
    cyc(1);
    check("t1_instrA", instr_D, 32'h1000_0000);
    check("t1_pcdA", pc_D, 0);
    cyc(1);
    check("t1_instrB", instr_D, 32'h1000_0001);
    check("t1_pcdB", pc_D, 4);
    check("t1_pcF", pc_F, 8);

    // Stall for three cycles at pc_F=8
    stall_F = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("t2_pcF", pc_F, 8);
      check("t2_instr", instr_D, 32'h1000_0001);
      check("t2_cnt", fetch_count, 2);
    end
    stall_F = 1'b0;
    cyc(1);
    check("t2_resume_instr", instr_D, 32'h1000_0002);
    check("t2_resume_pcd", pc_D, 8);
    check("t1_cnt3", fetch_count, 3);

    // Redirect beats stall
    redirect = 1'b1; redirect_pc = 64'h40; stall_F = 1'b1;
    cyc(1);
    check("t3_valid", valid_D, 0);
    check("t3_pcF", pc_F, 64'h40);
    redirect = 1'b0; stall_F = 1'b0;
    cyc(1);
    check("t3_instr", instr_D, 32'h1000_0010);
    check("t3_pcd", pc_D, 64'h40);

    // Reset while running mid-stall
    stall_F = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("t6b_pc", pc_F, 0);
    check("t6b_cnt", fetch_count, 0);
    check("t6b_valid", valid_D, 0);
    reset = 1'b0; stall_F = 1'b0;
    cyc(1);
    check("t6b_boot", valid_D, 0);
    cyc(1);
    check("t6b_refetch", instr_D, 32'h1000_0000);

    // Halt idiom at ROM[5]
    rom[5] = HW;
    restart();
    cyc(6);
    check("t4_instr", instr_D, HW);
    check("t4_valid1", valid_D, 1);
    check("t4_pcd", pc_D, 64'h14);
    redirect = 1'b1; redirect_pc = 64'h0; stall_F = 1'b1;
    cyc(1);
    check("t4_valid0", valid_D, 0);
    check("t4_halted", halted, 1);
    check("t4_pcF", pc_F, 64'h14);
    cyc(2);
    check("t4_pcF_held", pc_F, 64'h14);
    check("t4_cnt", fetch_count, 6);
    redirect = 1'b0; stall_F = 1'b0;

    // Reset out of HALT
    reset = 1'b1;
    cyc(1);
    check("t6a_halted", halted, 0);
    check("t6a_pc", pc_F, 0);
    rom[5] = 32'h1000_0005;
    reset = 1'b0;
    cyc(2);
    check("t6a_refetch", instr_D, 32'h1000_0000);

    // Misaligned redirect, then confirm inputs are ignored in FAULT
    redirect = 1'b1; redirect_pc = 64'h102;
    cyc(1);
    check("t5a_fault", fault, 1);
    check("t5a_valid", valid_D, 0);
    check("t5a_pc", pc_F, 4);
    redirect_pc = 64'h40;
    cyc(1);
    check("t5a_pc_held", pc_F, 4);

    // Out-of-range redirect
    restart();
    redirect = 1'b1; redirect_pc = 64'h100;
    cyc(1);
    check("t5b_fault", fault, 1);
    check("t5b_pc", pc_F, 0);

    // Sequential run off the end of the ROM
    restart();
    redirect = 1'b1; redirect_pc = 64'hF0;
    cyc(1);
    redirect = 1'b0;
    check("t5c_pcF0", pc_F, 64'hF0);
    cyc(4);
    check("t5c_instr63", instr_D, 32'h1000_003f);
    check("t5c_pcd", pc_D, 64'hFC);
    check("t5c_fault", fault, 1);
    check("t5c_pc", pc_F, 64'hFC);
    cyc(1);
    check("t5c_valid0", valid_D, 0);

    // Halt word at the last ROM slot: halt wins over the end-of-ROM fault
    rom[63] = HW;
    restart();
    redirect = 1'b1; redirect_pc = 64'hFC;
    cyc(1);
    redirect = 1'b0;
    cyc(1);
    check("t5d_halted", halted, 1);
    check("t5d_fault", fault, 0);
    rom[63] = 32'h1000_003f;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
